// File: rtl/ntps_mdio_master.sv
// AXI4-Lite controlled IEEE 802.3 Clause 22 MDIO master.
// Software launches one read or write frame at a time and polls STATUS for completion.
module ntps_mdio_master #(
  parameter int CLKDIV_RESET  = 24,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        axi_aclk,
  input  logic        reset,
  input  logic [4:0]  axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [4:0]  axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic        phy_mdc,
  output logic        phy_mdio_o,
  output logic        phy_mdio_t,
  input  logic        phy_mdio_i
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BITS - 1);

  state_t      state;
  logic [4:0]  regad;
  logic [4:0]  phyad;
  logic [15:0] wdata_reg;
  logic [15:0] rdata_reg;
  logic [7:0]  clkdiv;
  logic        done;
  logic        err;
  logic        op_rd;
  logic [7:0]  div_lat;
  logic [7:0]  div_cnt;
  logic [7:0]  bit_cnt;
  logic [31:0] tx_sr;
  logic [15:0] rx_sr;
  logic [31:0] rd_mux;
  logic        busy;
  logic        wr_fire;
  logic        rd_fire;
  logic        start_req;
  logic        unused_bits;

  assign busy      = (state != IDLE);
  assign wr_fire   = axi_awready && axi_awvalid && axi_wvalid;
  assign rd_fire   = axi_arready && axi_arvalid;
  assign start_req = wr_fire && (axi_awaddr[4:2] == 3'd0) && axi_wdata[0];
  assign axi_rresp = 2'b00;
  assign unused_bits = ^{axi_wstrb, axi_awaddr[1:0], axi_araddr[1:0], axi_wdata[31:16]};

  always_comb begin
    rd_mux = 32'h0;
    case (axi_araddr[4:2])
      3'd1:    rd_mux = {29'h0, err, done, busy};
      3'd2:    rd_mux = {19'h0, phyad, 3'h0, regad};
      3'd3:    rd_mux = {16'h0, wdata_reg};
      3'd4:    rd_mux = {16'h0, rdata_reg};
      3'd5:    rd_mux = {24'h0, clkdiv};
      default: rd_mux = 32'h0;
    endcase
  end

  // AXI-Lite handshakes and the software-visible configuration registers
  always_ff @(posedge axi_aclk or posedge reset) begin
    if (reset) begin
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= 2'b00;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= 32'h0;
      regad       <= 5'h0;
      phyad       <= 5'h0;
      wdata_reg   <= 16'h0;
      clkdiv      <= 8'(CLKDIV_RESET);
    end else begin
      axi_awready <= axi_awvalid && axi_wvalid && !axi_bvalid && !axi_awready;
      axi_wready  <= axi_awvalid && axi_wvalid && !axi_bvalid && !axi_awready;
      if (wr_fire) begin
        axi_bvalid <= 1'b1;
        axi_bresp  <= (start_req && busy) ? 2'b10 : 2'b00;
        case (axi_awaddr[4:2])
          3'd2: begin
            phyad <= axi_wdata[12:8];
            regad <= axi_wdata[4:0];
          end
          3'd3:    wdata_reg <= axi_wdata[15:0];
          3'd5:    clkdiv    <= axi_wdata[7:0];
          default: ;
        endcase
      end else if (axi_bvalid && axi_bready) begin
        axi_bvalid <= 1'b0;
      end

      axi_arready <= axi_arvalid && !axi_rvalid && !axi_arready;
      if (rd_fire) begin
        axi_rvalid <= 1'b1;
        axi_rdata  <= rd_mux;
      end else if (axi_rvalid && axi_rready) begin
        axi_rvalid <= 1'b0;
      end
    end
  end

  // Frame sequencer: MDIO changes on the MDC falling step, input sampled on the rising step
  always_ff @(posedge axi_aclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phy_mdc    <= 1'b0;
      phy_mdio_o <= 1'b1;
      phy_mdio_t <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      op_rd      <= 1'b0;
      rdata_reg  <= 16'h0;
      div_lat    <= 8'h0;
      div_cnt    <= 8'h0;
      bit_cnt    <= 8'h0;
      tx_sr      <= 32'h0;
      rx_sr      <= 16'h0;
    end else begin
      if (start_req && busy) err <= 1'b1;
      if (start_req && !busy) begin
        done       <= 1'b0;
        err        <= 1'b0;
        op_rd      <= axi_wdata[1];
        div_lat    <= clkdiv;
        div_cnt    <= 8'h0;
        bit_cnt    <= 8'h0;
        tx_sr      <= {2'b01, axi_wdata[1] ? 2'b10 : 2'b01, phyad, regad, 2'b10,
                       axi_wdata[1] ? 16'h0 : wdata_reg};
        phy_mdc    <= 1'b0;
        phy_mdio_t <= 1'b0;
        if (PREAMBLE_BITS == 0) begin
          state      <= HDR;
          phy_mdio_o <= 1'b0;
        end else begin
          state      <= PRE;
          phy_mdio_o <= 1'b1;
        end
      end else if (busy) begin
        if (div_cnt == div_lat) begin
          div_cnt <= 8'h0;
          phy_mdc <= ~phy_mdc;
          if (!phy_mdc) begin
            if (state == DATA) rx_sr <= {rx_sr[14:0], phy_mdio_i};
          end else begin
            case (state)
              PRE: begin
                if (bit_cnt == PRE_LAST) begin
                  state      <= HDR;
                  bit_cnt    <= 8'h0;
                  phy_mdio_o <= tx_sr[31];
                end else begin
                  bit_cnt <= bit_cnt + 8'd1;
                end
              end
              HDR: begin
                tx_sr      <= {tx_sr[30:0], 1'b0};
                phy_mdio_o <= tx_sr[30];
                if (bit_cnt == 8'd13) begin
                  state      <= TA;
                  bit_cnt    <= 8'h0;
                  phy_mdio_t <= op_rd;
                end else begin
                  bit_cnt <= bit_cnt + 8'd1;
                end
              end
              TA: begin
                tx_sr      <= {tx_sr[30:0], 1'b0};
                phy_mdio_o <= tx_sr[30];
                if (bit_cnt == 8'd1) begin
                  state   <= DATA;
                  bit_cnt <= 8'h0;
                end else begin
                  bit_cnt <= bit_cnt + 8'd1;
                end
              end
              DATA: begin
                if (bit_cnt == 8'd15) begin
                  state      <= IDLE;
                  done       <= 1'b1;
                  phy_mdio_t <= 1'b1;
                  phy_mdio_o <= 1'b1;
                  if (op_rd) rdata_reg <= rx_sr;
                end else begin
                  tx_sr      <= {tx_sr[30:0], 1'b0};
                  phy_mdio_o <= tx_sr[30];
                  bit_cnt    <= bit_cnt + 8'd1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ntps_mdio_master.sv
// Directed bench for ntps_mdio_master: a frame-level model predicts MDC/MDIO every cycle,
// AXI transactions are checked against hand-computed register values.
module tb_ntps_mdio_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = 4'hF;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b0;
  logic [4:0]  axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b0;
  logic        phy_mdc;
  logic        phy_mdio_o;
  logic        phy_mdio_t;
  logic        phy_mdio_i = 1'b1;

  ntps_mdio_master dut (
    .axi_aclk(clk), .reset(reset),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .phy_mdc(phy_mdc), .phy_mdio_o(phy_mdio_o), .phy_mdio_t(phy_mdio_t), .phy_mdio_i(phy_mdio_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: shadow registers and the frame currently on the wire
  logic [4:0]  m_phyad = '0;
  logic [4:0]  m_regad = '0;
  logic [15:0] m_wdata = '0;
  logic [7:0]  m_clkdiv = 8'd24;
  bit          m_active = 1'b0;
  bit          m_rd = 1'b0;
  int          m_start = 0;
  int          m_len = 0;
  int          m_div = 0;
  logic [63:0] m_frame = '0;
  logic [15:0] m_rdval = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] build_frame(input bit rd, input logic [4:0] pa,
                                               input logic [4:0] ra, input logic [15:0] d);
    return {32'hFFFF_FFFF, 2'b01, rd ? 2'b10 : 2'b01, pa, ra, rd ? 2'b11 : 2'b10, rd ? 16'h0 : d};
  endfunction

  // Per-cycle comparison of the MDIO pins against the frame model; also acts as the PHY
  always @(negedge clk) begin : monitor
    int k, p, b;
    logic e_mdc, e_t, e_o;
    if (!reset) begin
      e_mdc = 1'b0; e_t = 1'b1; e_o = 1'b1;
      phy_mdio_i = 1'b1;
      if (m_active && cyc >= m_start && cyc < m_start + m_len) begin
        k = cyc - m_start;
        p = 2 * (m_div + 1);
        b = k / p;
        e_mdc = ((k % p) >= (m_div + 1));
        e_t = m_rd && (b >= 46);
        e_o = m_frame[63 - b];
        if (m_rd && b >= 48) phy_mdio_i = m_rdval[63 - b];
      end
      check("phy_mdc", phy_mdc, e_mdc);
      check("phy_mdio_t", phy_mdio_t, e_t);
      if (!e_t) check("phy_mdio_o", phy_mdio_o, e_o);
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    int hs;
    logic [1:0] e_resp;
    axi_awaddr = a; axi_wdata = d; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    @(negedge clk);
    while (!axi_awready && n < 20) begin @(negedge clk); n++; end
    check("awready", axi_awready, 1'b1);
    check("wready", axi_wready, 1'b1);
    hs = cyc + 1;
    e_resp = 2'b00;
    if (a[4:2] == 3'd0 && d[0]) begin
      if (m_active && hs <= m_start + m_len) e_resp = 2'b10;
      else begin
        m_active = 1'b1;
        m_start  = hs;
        m_rd     = d[1];
        m_div    = int'(m_clkdiv);
        m_len    = 64 * 2 * (m_div + 1);
        m_frame  = build_frame(d[1], m_phyad, m_regad, m_wdata);
      end
    end else if (a[4:2] == 3'd2) begin
      m_phyad = d[12:8]; m_regad = d[4:0];
    end else if (a[4:2] == 3'd3) m_wdata = d[15:0];
    else if (a[4:2] == 3'd5) m_clkdiv = d[7:0];
    @(negedge clk);
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    check("bvalid", axi_bvalid, 1'b1);
    check("bresp", axi_bresp, e_resp);
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    int n = 0;
    axi_araddr = a; axi_arvalid = 1'b1;
    @(negedge clk);
    while (!axi_arready && n < 20) begin @(negedge clk); n++; end
    check({name, "_arready"}, axi_arready, 1'b1);
    @(negedge clk);
    axi_arvalid = 1'b0;
    check({name, "_rvalid"}, axi_rvalid, 1'b1);
    check(name, axi_rdata, exp);
    check({name, "_rresp"}, axi_rresp, 2'b00);
    axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_phyad = '0; m_regad = '0; m_wdata = '0; m_clkdiv = 8'd24;
  endtask

  initial begin
    int s;
    logic [63:0] fr;
    // Reset asserted asynchronously between clock edges
    #3 reset = 1'b1;
    #1;
    check("rst_awready", axi_awready, 1'b0);
    check("rst_wready", axi_wready, 1'b0);
    check("rst_bvalid", axi_bvalid, 1'b0);
    check("rst_arready", axi_arready, 1'b0);
    check("rst_rvalid", axi_rvalid, 1'b0);
    check("rst_bresp", axi_bresp, 2'b00);
    check("rst_rresp", axi_rresp, 2'b00);
    check("rst_rdata", axi_rdata, 32'h0);
    check("rst_mdc", phy_mdc, 1'b0);
    check("rst_mdio_o", phy_mdio_o, 1'b1);
    check("rst_mdio_t", phy_mdio_t, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_check("clkdiv_rst", 5'h14, 32'h18);
    read_check("status_rst", 5'h04, 32'h0);

    // Write frame at CLKDIV = 1
    fr = build_frame(1'b0, 5'd1, 5'd3, 16'hBEEF);
    check("model_wr_frame", fr, 64'hFFFF_FFFF_508E_BEEF);
    axi_write(5'h08, 32'h0103);
    axi_write(5'h0C, 32'hBEEF);
    axi_write(5'h14, 32'h1);
    axi_write(5'h00, 32'h1);
    check("model_wr_len", m_len, 256);
    wait_cyc(m_start + m_len - 2);
    read_check("status_last_cycle", 5'h04, 32'h1);
    wait_cyc(m_start + m_len + 3);
    read_check("status_wr_done", 5'h04, 32'h2);

    // START while busy at CLKDIV = 3; CLKDIV change must wait for the next frame
    axi_write(5'h0C, 32'h1357);
    axi_write(5'h08, 32'h0A11);
    axi_write(5'h14, 32'h3);
    axi_write(5'h00, 32'h1);
    s = m_start;
    wait_cyc(s + 20);
    axi_write(5'h00, 32'h1);
    axi_write(5'h14, 32'h0);
    read_check("status_busy_err", 5'h04, 32'h5);
    wait_cyc(s + m_len + 2);
    read_check("status_err_done", 5'h04, 32'h6);
    read_check("clkdiv_new", 5'h14, 32'h0);

    // Read frame at CLKDIV = 0, PHY returns 0x1234
    fr = build_frame(1'b1, 5'd31, 5'd2, 16'h0);
    check("model_rd_hdr", fr[31:18], 14'h1BE2);
    m_rdval = 16'h1234;
    axi_write(5'h08, 32'h1F02);
    axi_write(5'h00, 32'h3);
    s = m_start;
    wait_cyc(s + 91);
    check("rd_t_bit45", phy_mdio_t, 1'b0);
    @(negedge clk);
    check("rd_t_bit46", phy_mdio_t, 1'b1);
    wait_cyc(s + m_len - 1);
    read_check("status_rd_done", 5'h04, 32'h2);
    read_check("rdata_1234", 5'h10, 32'h0000_1234);

    // Write-response backpressure with a second write pending
    axi_awaddr = 5'h0C; axi_wdata = 32'h4321; axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    @(negedge clk);
    check("bp_awready", axi_awready, 1'b1);
    @(negedge clk);
    axi_wdata = 32'h8765;
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid", axi_bvalid, 1'b1);
      check("bp_bresp", axi_bresp, 2'b00);
      check("bp_no_awready", axi_awready, 1'b0);
      check("bp_no_wready", axi_wready, 1'b0);
      @(negedge clk);
    end
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    m_wdata = 16'h4321;
    read_check("bp_wdata", 5'h0C, 32'h4321);

    // Read-data backpressure with a second read pending
    axi_araddr = 5'h0C; axi_arvalid = 1'b1;
    @(negedge clk);
    check("bp_arready", axi_arready, 1'b1);
    @(negedge clk);
    axi_araddr = 5'h14;
    for (int i = 0; i < 10; i++) begin
      check("bp_rvalid", axi_rvalid, 1'b1);
      check("bp_rdata", axi_rdata, 32'h4321);
      check("bp_no_arready", axi_arready, 1'b0);
      @(negedge clk);
    end
    axi_arvalid = 1'b0; axi_rready = 1'b1;
    @(negedge clk);
    axi_rready = 1'b0;

    // Unmapped offset
    axi_write(5'h1C, 32'hFFFF_FFFF);
    read_check("unmapped", 5'h1C, 32'h0);
    read_check("addr_kept", 5'h08, 32'h1F02);

    // Reset in the middle of bit 50 of a read
    m_rdval = 16'h5A5A;
    axi_write(5'h00, 32'h3);
    s = m_start;
    wait_cyc(s + 101);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_mdc", phy_mdc, 1'b0);
    check("mid_rst_mdio_o", phy_mdio_o, 1'b1);
    check("mid_rst_mdio_t", phy_mdio_t, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_check("status_after_rst", 5'h04, 32'h0);
    read_check("clkdiv_after_rst", 5'h14, 32'h18);
    m_rdval = 16'hA5C3;
    axi_write(5'h08, 32'h0A05);
    axi_write(5'h00, 32'h3);
    wait_cyc(m_start + m_len + 2);
    read_check("status_rd2_done", 5'h04, 32'h2);
    read_check("rdata_a5c3", 5'h10, 32'h0000_A5C3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
